sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Successive-approximation search controller that drives the `b` input of the team's `comp` magnitude comparator.
- Consumes the comparator's `eq`/`lt`/`gt` flags to recover an unknown `WIDTH`-bit value held on the comparator's `a` input.
- It is the initiator side of the comparator interface: it generates trial values and reacts to the comparator's answers.
- Serves as the sequential companion to the combinational comparator, as a reusable ADC-style search engine.

Parameters:
- WIDTH, 4, width of the searched value, the trial value and the result (WIDTH >= 2).
- CNT_W, $clog2(WIDTH)+1, width of the trial counter output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a new search; sampled only in IDLE.
- cmp_eq  input  1  comparator eq (target == guess).
- cmp_lt  input  1  comparator lt (target < guess).
- cmp_gt  input  1  comparator gt (target > guess).
- guess  output  WIDTH  trial value driven to the comparator `b` input.
- busy  output  1  high while searching.
- done  output  1  one-cycle pulse at the end of a search.
- err  output  1  valid with done; the comparator flags were not one-hot.
- result  output  WIDTH  recovered value; held until the next start.
- trials  output  CNT_W  number of trial cycles the last search used; held.

Interface decision (already decided): one clock, `clk`; reset `rst` is synchronous and active-high.

Behaviour:
- Reset values: state = IDLE; guess = 0; busy = 0; done = 0; err = 0; result = 0; trials = 0; bit index = WIDTH-1.
- Reset asserted mid-search aborts the search immediately. No done pulse is produced.
- Comparator path is combinational. Flags are sampled on the same edge that ends each TRIAL cycle, for the guess driven during that cycle.
- States: IDLE, TRIAL, DONE.
- IDLE:
  - On start = 1: guess <= 1 << (WIDTH-1); idx <= WIDTH-1; trials <= 0; err <= 0; go to TRIAL.
  - Otherwise hold all outputs.
- TRIAL (busy = 1); trials increments on every TRIAL edge:
  - Flags not exactly one-hot (none set, or more than one set): result <= 0; err <= 1; go to DONE.
  - cmp_eq: result <= guess; go to DONE (early exit).
  - cmp_gt: keep bit idx. If idx == 0, result <= guess and go to DONE. Else guess[idx-1] <= 1; idx <= idx-1.
  - cmp_lt: clear bit idx. If idx == 0, result <= guess with bit 0 cleared and go to DONE. Else clear bit idx, set bit idx-1; idx <= idx-1.
- DONE: done = 1 for exactly one cycle; busy = 0; then go to IDLE. A start asserted in DONE is ignored.
- start asserted while busy is ignored; the current search is not restarted.
- guess holds its last trial value outside TRIAL.
- Latency: start edge, then 1..WIDTH TRIAL cycles, then one DONE cycle. Maximum start-to-done = WIDTH+1 edges.
- Arithmetic: unsigned only. Bit manipulation only, no adders except the trials counter. trials saturates at WIDTH.

Decomposition:
- Shared package: state enum (IDLE/TRIAL/DONE), helper function for the MSB-one initial guess, CNT_W derivation.
- RTL is a single module; no sub-module is natural.
- Bench instantiates the existing `comp` as the responder, with a = target register and b = guess.

Test Plan:
- target = 4'b1100, start pulse: trials 1000(gt), 1100(eq) -> done at edge 3 after start, result = 1100, trials = 2, err = 0.
- target = 4'b0000: guesses 1000, 0100, 0010, 0001, all lt -> result = 0000, trials = 4, done at edge 5.
- target = 4'b1111: guesses 1000, 1100, 1110, 1111(eq) -> result = 1111, trials = 4. Target 4'b1000 -> eq on first trial, trials = 1.
- Exhaustive sweep of targets 0..15 with `comp` in the loop -> result == target, err = 0, trials <= 4, exactly one done pulse per start.
- Replace `comp` flags with forced cmp_eq = cmp_lt = 1 on the second trial -> done with err = 1, result = 0. Forced all-zero flags -> same.
- Assert rst during the 2nd TRIAL cycle -> next cycle all outputs at reset values, no done. start during busy -> ignored, search completes unchanged.

Source files
------------

// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_search_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRIAL = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int MAX_W = 32;

  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  // First trial value: only the MSB of a width-bit word set.
  function automatic logic [MAX_W-1:0] msb_one(input int width);
    return MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Search-controller bus: start request, comparator flags in, trial/result/status out.
interface sar_search_if
  import sar_search_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_w(WIDTH)
) ();

  logic             start;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             cmp_gt;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] trials;

  modport master (
    input  start, cmp_eq, cmp_lt, cmp_gt,
    output guess, busy, done, err, result, trials
  );

  modport slave (
    output start, cmp_eq, cmp_lt, cmp_gt,
    input  guess, busy, done, err, result, trials
  );

endinterface

// File: rtl/comp.sv
// Combinational unsigned magnitude comparator: flags describe a relative to b.
// Zero latency, no flow control.
module comp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/sar_search.sv
// SAR search engine driving a comparator's b input; 1..WIDTH trial cycles plus one DONE cycle.
// start is honoured only in IDLE; requests while busy or in DONE are dropped.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  sar_search_if.master bus
);

  localparam logic [WIDTH-1:0] GUESS_INIT = WIDTH'(msb_one(WIDTH));
  localparam logic [CNT_W-1:0] TRIALS_MAX = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] mask_q, mask_d;  // one-hot marker of the bit under test
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] trials_q, trials_d;
  logic             err_q, err_d;
  logic             one_hot;

  assign one_hot = (bus.cmp_eq ^ bus.cmp_lt ^ bus.cmp_gt) &
                   ~(bus.cmp_eq & bus.cmp_lt & bus.cmp_gt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      mask_q   <= GUESS_INIT;
      result_q <= '0;
      trials_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      trials_q <= trials_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    mask_d   = mask_q;
    result_d = result_q;
    trials_d = trials_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          guess_d  = GUESS_INIT;
          mask_d   = GUESS_INIT;
          trials_d = '0;
          err_d    = 1'b0;
          state_d  = S_TRIAL;
        end
      end
      S_TRIAL: begin
        if (trials_q != TRIALS_MAX) trials_d = trials_q + CNT_W'(1);
        if (!one_hot) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else if (bus.cmp_eq) begin
          result_d = guess_q;
          state_d  = S_DONE;
        end else if (bus.cmp_gt) begin
          if (mask_q[0]) begin
            result_d = guess_q;
            state_d  = S_DONE;
          end else begin
            guess_d = guess_q | (mask_q >> 1);
            mask_d  = mask_q >> 1;
          end
        end else begin
          // Target below the trial: the bit under test is wrong, drop it.
          if (mask_q[0]) begin
            result_d = guess_q & ~mask_q;
            state_d  = S_DONE;
          end else begin
            guess_d = (guess_q & ~mask_q) | (mask_q >> 1);
            mask_d  = mask_q >> 1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = (state_q == S_TRIAL);
  assign bus.done   = (state_q == S_DONE);
  assign bus.err    = err_q;
  assign bus.result = result_q;
  assign bus.trials = trials_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search with the comp comparator closing the loop.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] target;
  logic       force_en;
  logic       f_eq, f_lt, f_gt;
  logic       c_eq, c_lt, c_gt;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         edges;
  logic [3:0] gseq[$];

  always #5 clk = ~clk;

  sar_search_if #(.WIDTH(4)) bus ();

  sar_search #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  comp #(.WIDTH(4)) u_comp (
    .a  (target),
    .b  (bus.guess),
    .eq (c_eq),
    .lt (c_lt),
    .gt (c_gt)
  );

  assign bus.cmp_eq = force_en ? f_eq : c_eq;
  assign bus.cmp_lt = force_en ? f_lt : c_lt;
  assign bus.cmp_gt = force_en ? f_gt : c_gt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // One full search; leaves the bench at the negedge after the done pulse ended.
  task automatic run(input logic [3:0] tgt, input bit hold);
    target = tgt;
    gseq.delete();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    if (bus.busy) gseq.push_back(bus.guess);
    while (!bus.done && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.busy) gseq.push_back(bus.guess);
    end
    if (edges >= 20) chk("timeout", 32'(bus.done), 32'd1);
    bus.start = 1'b0;
  endtask

  task automatic after_done();
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  task automatic force_run(input logic feq, input logic flt, input logic fgt);
    target = 4'b1100;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    force_en = 1'b1;
    {f_eq, f_lt, f_gt} = {feq, flt, fgt};
    @(posedge clk);
    @(negedge clk);
    chk("force_done", 32'(bus.done), 32'd1);
    chk("force_err", 32'(bus.err), 32'd1);
    chk("force_result", 32'(bus.result), 32'd0);
    chk("force_trials", 32'(bus.trials), 32'd2);
    force_en = 1'b0;
    after_done();
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    target    = '0;
    force_en  = 1'b0;
    {f_eq, f_lt, f_gt} = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_guess", 32'(bus.guess), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_trials", 32'(bus.trials), 32'd0);
    rst = 1'b0;

    run(4'b1100, 1'b0);
    chk("t1100_edges", 32'(edges), 32'd3);
    chk("t1100_result", 32'(bus.result), 32'hC);
    chk("t1100_trials", 32'(bus.trials), 32'd2);
    chk("t1100_err", 32'(bus.err), 32'd0);
    chk("t1100_g0", 32'(gseq[0]), 32'h8);
    chk("t1100_g1", 32'(gseq[1]), 32'hC);
    after_done();

    run(4'b0000, 1'b0);
    chk("t0000_edges", 32'(edges), 32'd5);
    chk("t0000_result", 32'(bus.result), 32'h0);
    chk("t0000_trials", 32'(bus.trials), 32'd4);
    chk("t0000_g1", 32'(gseq[1]), 32'h4);
    chk("t0000_g2", 32'(gseq[2]), 32'h2);
    chk("t0000_g3", 32'(gseq[3]), 32'h1);
    after_done();

    run(4'b1111, 1'b0);
    chk("t1111_edges", 32'(edges), 32'd5);
    chk("t1111_result", 32'(bus.result), 32'hF);
    chk("t1111_trials", 32'(bus.trials), 32'd4);
    chk("t1111_g1", 32'(gseq[1]), 32'hC);
    chk("t1111_g2", 32'(gseq[2]), 32'hE);
    chk("t1111_g3", 32'(gseq[3]), 32'hF);
    after_done();

    run(4'b1000, 1'b0);
    chk("t1000_edges", 32'(edges), 32'd2);
    chk("t1000_result", 32'(bus.result), 32'h8);
    chk("t1000_trials", 32'(bus.trials), 32'd1);
    after_done();

    for (int t = 0; t < 16; t++) begin
      run(4'(t), 1'b0);
      chk("sweep_result", 32'(bus.result), 32'(t));
      chk("sweep_err", 32'(bus.err), 32'd0);
      chk("sweep_trials_le4", 32'(bus.trials <= 3'd4), 32'd1);
      chk("sweep_latency", 32'(edges), 32'(bus.trials) + 32'd1);
      after_done();
    end

    // Abort during the second trial cycle; prior result 1111 must be cleared.
    target = 4'b0101;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_guess", 32'(bus.guess), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_trials", 32'(bus.trials), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", 32'(bus.done), 32'd0);

    // start held through the whole search and into DONE is ignored.
    run(4'b0110, 1'b1);
    chk("hold_edges", 32'(edges), 32'd4);
    chk("hold_result", 32'(bus.result), 32'h6);
    chk("hold_trials", 32'(bus.trials), 32'd3);
    after_done();
    chk("hold_idle", 32'(bus.busy), 32'd0);

    run(4'b1010, 1'b0);
    after_done();
    force_run(1'b1, 1'b1, 1'b0);
    run(4'b1010, 1'b0);
    chk("pre_zero_result", 32'(bus.result), 32'hA);
    after_done();
    force_run(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
